// File: rtl/hp_au_seq.sv
// hp_au_seq - sequential arithmetic unit with valid/ready handshakes.
//
// Performs binary add/sub in a single execute cycle, or multi-digit BCD
// add/sub one digit per cycle (least-significant digit first). Results and
// status flags are registered and held until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   sel        00 bin add, 01 bin sub, 10 BCD add, 11 BCD sub
//   out_valid  result and flags valid (DONE state)
//   out_ready  consumer accepts result
//   result     WIDTH-bit result
//   cout       carry out; for subtraction 1 = no borrow
//   ovf        signed overflow (binary only)
//   bcd_err    some operand digit > 9 (BCD only)
//   zero       result == 0
module hp_au_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             bcd_err,
    output logic             zero
);

    localparam int unsigned NDIG = WIDTH / 4;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIN,
        S_BCD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    dig_q, dig_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;

    // Binary datapath
    logic [WIDTH-1:0] b_bin;
    logic [WIDTH:0]   bin_sum;
    logic             bin_ovf;

    // BCD digit datapath
    logic [3:0]       bcd_bp;
    logic [4:0]       bcd_s;
    logic [3:0]       bcd_digit;
    logic             bcd_c;
    logic             last_digit;

    function automatic logic has_bad_digit(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        logic             bad;
        t   = v;
        bad = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (t[3:0] > 4'd9) bad = 1'b1;
            t = t >> 4;
        end
        return bad;
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign bcd_err   = err_q;
    assign zero      = zero_q;

    always_comb begin
        b_bin   = sub_q ? ~b_q : b_q;
        bin_sum = {1'b0, a_q} + {1'b0, b_bin} + {{WIDTH{1'b0}}, sub_q};
        // Overflow when both addends share a sign that the sum does not.
        bin_ovf = (a_q[WIDTH-1] == b_bin[WIDTH-1]) &&
                  (bin_sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    // The operand registers are shifted right one digit per BCD cycle, so the
    // current digit is always in bits [3:0].
    always_comb begin
        bcd_bp = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        bcd_s  = {1'b0, a_q[3:0]} + {1'b0, bcd_bp} + {4'b0000, carry_q};
        if (bcd_s > 5'd9) begin
            bcd_digit = bcd_s[3:0] + 4'd6;
            bcd_c     = 1'b1;
        end else begin
            bcd_digit = bcd_s[3:0];
            bcd_c     = 1'b0;
        end
        last_digit = (dig_q == CW'(NDIG - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        dig_d    = dig_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sel[0];
                    dig_d   = '0;
                    // BCD subtraction starts with an incoming carry of 1
                    // (nines' complement + 1); unused by binary ops.
                    carry_d = sel[0];
                    ovf_d   = 1'b0;
                    err_d   = sel[1] ? (has_bad_digit(a) | has_bad_digit(b)) : 1'b0;
                    state_d = sel[1] ? S_BCD : S_BIN;
                end
            end

            S_BIN: begin
                result_d = bin_sum[WIDTH-1:0];
                cout_d   = bin_sum[WIDTH];
                ovf_d    = bin_ovf;
                zero_d   = (bin_sum[WIDTH-1:0] == '0);
                state_d  = S_DONE;
            end

            S_BCD: begin
                // New digit enters at the top; after NDIG cycles every digit
                // has been shifted down to its final position.
                result_d              = result_q >> 4;
                result_d[WIDTH-1 -: 4] = bcd_digit;
                carry_d               = bcd_c;
                a_d                   = a_q >> 4;
                b_d                   = b_q >> 4;
                dig_d                 = dig_q + 1'b1;
                if (last_digit) begin
                    cout_d  = bcd_c;
                    ovf_d   = 1'b0;
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            dig_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            dig_q    <= dig_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_hp_au_seq.sv
module tb_hp_au_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_t = '0, b_t = '0;
    logic [1:0]  sel_t = '0;
    logic        iv8 = 1'b0, iv16 = 1'b0, or8 = 1'b0, or16 = 1'b0;

    logic       ir8, ov8, c8, o8, e8, z8;
    logic [7:0] r8;
    logic        ir16, ov16, c16, o16, e16, z16;
    logic [15:0] r16;

    int sel_w = 8;
    logic        m_ir, m_ov, m_c, m_o, m_e, m_z;
    logic [15:0] m_r;
    assign m_ir = (sel_w == 16) ? ir16 : ir8;
    assign m_ov = (sel_w == 16) ? ov16 : ov8;
    assign m_c  = (sel_w == 16) ? c16  : c8;
    assign m_o  = (sel_w == 16) ? o16  : o8;
    assign m_e  = (sel_w == 16) ? e16  : e8;
    assign m_z  = (sel_w == 16) ? z16  : z8;
    assign m_r  = (sel_w == 16) ? r16  : {8'h00, r8};

    int ncmp = 0;
    int nfail = 0;

    hp_au_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a_t[7:0]), .b(b_t[7:0]), .sel(sel_t),
        .out_valid(ov8), .out_ready(or8), .result(r8),
        .cout(c8), .ovf(o8), .bcd_err(e8), .zero(z8)
    );

    hp_au_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a_t), .b(b_t), .sel(sel_t),
        .out_valid(ov16), .out_ready(or16), .result(r16),
        .cout(c16), .ovf(o16), .bcd_err(e16), .zero(z16)
    );

    // Reference: binary via integer arithmetic; BCD via decimal values when
    // all digits are legal, otherwise by the per-digit correction rule.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] sel, output logic [15:0] r,
                                  output logic [3:0] f);
        longint mod, ua, ub, sa, sb, rs, ss, va, vb, p10, v;
        int nd, cc, bp, s, dg;
        int da[4];
        int db[4];
        logic c, o, e;
        mod = longint'(1) << w;
        ua = longint'(a) % mod;
        ub = longint'(b) % mod;
        nd = w / 4;
        o = 1'b0;
        e = 1'b0;
        r = '0;
        if (!sel[1]) begin
            sa = (ua >= mod / 2) ? ua - mod : ua;
            sb = (ub >= mod / 2) ? ub - mod : ub;
            if (!sel[0]) begin
                rs = ua + ub; c = (rs >= mod); ss = sa + sb;
            end else begin
                rs = ua - ub; c = (rs >= 0); ss = sa - sb;
            end
            r = 16'((rs + mod) % mod);
            o = (ss < -(mod / 2)) || (ss >= mod / 2);
        end else begin
            va = 0; vb = 0; p10 = 1;
            for (int i = 0; i < nd; i++) begin
                da[i] = int'((ua >> (4 * i)) & 15);
                db[i] = int'((ub >> (4 * i)) & 15);
                if (da[i] > 9 || db[i] > 9) e = 1'b1;
                va = va + da[i] * p10;
                vb = vb + db[i] * p10;
                p10 = p10 * 10;
            end
            if (!e) begin
                if (!sel[0]) begin rs = va + vb; c = (rs >= p10); end
                else begin rs = va - vb; c = (rs >= 0); end
                v = (rs + p10) % p10;
                for (int i = 0; i < nd; i++) begin
                    r = r | 16'((v % 10) << (4 * i));
                    v = v / 10;
                end
            end else begin
                cc = sel[0] ? 1 : 0;
                for (int i = 0; i < nd; i++) begin
                    bp = sel[0] ? ((9 - db[i]) & 15) : db[i];
                    s = da[i] + bp + cc;
                    if (s > 9) begin dg = (s + 6) & 15; cc = 1; end
                    else begin dg = s; cc = 0; end
                    r = r | 16'(dg << (4 * i));
                end
                c = (cc != 0);
            end
        end
        f = {c, o, e, (r == 16'h0000)};
    endfunction

    function automatic logic [15:0] rnd_operand(input int w, input bit bcd);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < w / 4; i++) begin
            if (bcd) v[4*i +: 4] = 4'($urandom_range(0, 9));
            else     v[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Drives one operation through the selected instance and completes the
    // result handshake; reports what it saw, judgement is left to callers.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] sel, output logic [15:0] r, output logic [3:0] f,
                          output int lat, output logic rdy_after, output bit to);
        sel_w = w;
        to = 1'b0; lat = 0; r = '0; f = '0; rdy_after = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20 && !m_ir; k++) @(negedge clk);
        if (!m_ir) begin to = 1'b1; return; end
        a_t = a; b_t = b; sel_t = sel;
        if (w == 16) iv16 = 1'b1; else iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0; iv16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (m_ov) begin lat = k; break; end
        end
        if (lat == 0) begin to = 1'b1; return; end
        r = m_r;
        f = {m_c, m_o, m_e, m_z};
        if (w == 16) or16 = 1'b1; else or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0; or16 = 1'b0;
        @(negedge clk);
        rdy_after = m_ir && !m_ov;
    endtask

    typedef struct packed {
        logic [4:0]  w;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sel;
        logic [15:0] r;
        logic [3:0]  f;   // {cout, ovf, bcd_err, zero}
    } vec_t;

    vec_t tab[11];

    task automatic test_reset();
        rst = 1'b1;
        sel_w = 8;
        a_t = 16'h0058; b_t = 16'h0067; sel_t = 2'b10;
        iv8 = 1'b1; iv16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ncmp++; if ({ov8, ov16} !== 2'b00) begin nfail++; $display("FAIL reset out_valid got %b exp 00", {ov8, ov16}); end
        ncmp++; if ({ir8, ir16} !== 2'b00) begin nfail++; $display("FAIL reset in_ready got %b exp 00", {ir8, ir16}); end
        ncmp++; if (r8 !== 8'h00) begin nfail++; $display("FAIL reset result8 got %h exp 00", r8); end
        ncmp++; if (r16 !== 16'h0000) begin nfail++; $display("FAIL reset result16 got %h exp 0000", r16); end
        ncmp++; if ({c8, o8, e8, z8, c16, o16, e16, z16} !== 8'h00) begin
            nfail++; $display("FAIL reset flags got %b exp 00000000", {c8, o8, e8, z8, c16, o16, e16, z16}); end
        @(posedge clk);
        #1;
        rst = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
        @(negedge clk);
        ncmp++; if ({ir8, ir16} !== 2'b11) begin nfail++; $display("FAIL reset_release in_ready got %b exp 11", {ir8, ir16}); end
        ncmp++; if ({ov8, ov16} !== 2'b00) begin nfail++; $display("FAIL reset_release out_valid got %b exp 00", {ov8, ov16}); end
    endtask

    task automatic test_table(input bit want_bcd);
        logic [15:0] r; logic [3:0] f; int lat, el; logic rdy; bit to; string nm;
        for (int i = 0; i < 11; i++) begin
            if (tab[i].sel[1] != want_bcd) continue;
            nm = $sformatf("%s[%0d]", want_bcd ? "bcd" : "bin", i);
            run_op(int'(tab[i].w), tab[i].a, tab[i].b, tab[i].sel, r, f, lat, rdy, to);
            el = tab[i].sel[1] ? int'(tab[i].w) / 4 + 1 : 2;
            ncmp++;
            if (to !== 1'b0) begin nfail++; $display("FAIL %s timeout got %0b exp 0", nm, to); end
            else begin
                ncmp++; if (r !== tab[i].r) begin nfail++; $display("FAIL %s result got %h exp %h", nm, r, tab[i].r); end
                ncmp++; if (f !== tab[i].f) begin nfail++; $display("FAIL %s flags(c,o,e,z) got %b exp %b", nm, f, tab[i].f); end
                ncmp++; if (lat != el) begin nfail++; $display("FAIL %s latency got %0d exp %0d", nm, lat, el); end
                ncmp++; if (rdy !== 1'b1) begin nfail++; $display("FAIL %s in_ready_after got %b exp 1", nm, rdy); end
            end
        end
    endtask

    task automatic test_bin();
        test_table(1'b0);
    endtask

    task automatic test_bcd();
        test_table(1'b1);
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, er; logic [3:0] f, ef; logic [1:0] s; int lat, el, w; logic rdy; bit to, vb;
        for (int i = 0; i < 50; i++) begin
            w = (i < 30) ? 8 : 16;
            s = 2'($urandom_range(0, 3));
            vb = ($urandom_range(0, 3) != 0);
            a = rnd_operand(w, vb);
            b = rnd_operand(w, vb);
            model(w, a, b, s, er, ef);
            el = s[1] ? w / 4 + 1 : 2;
            run_op(w, a, b, s, r, f, lat, rdy, to);
            ncmp++;
            if (to !== 1'b0) begin nfail++; $display("FAIL rnd[%0d] timeout got %0b exp 0", i, to); end
            else begin
                ncmp++; if (r !== er) begin nfail++; $display("FAIL rnd[%0d] w%0d sel%b %h,%h result got %h exp %h", i, w, s, a, b, r, er); end
                ncmp++; if (f !== ef) begin nfail++; $display("FAIL rnd[%0d] w%0d sel%b %h,%h flags got %b exp %b", i, w, s, a, b, f, ef); end
                ncmp++; if (lat != el) begin nfail++; $display("FAIL rnd[%0d] latency got %0d exp %0d", i, lat, el); end
                ncmp++; if (rdy !== 1'b1) begin nfail++; $display("FAIL rnd[%0d] in_ready_after got %b exp 1", i, rdy); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        sel_w = 8;
        @(negedge clk);
        for (int k = 0; k < 20 && !ir8; k++) @(negedge clk);
        a_t = 16'h0058; b_t = 16'h0067; sel_t = 2'b10; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov8) begin seen = 1'b1; break; end
        end
        ncmp++;
        if (!seen) begin nfail++; $display("FAIL bp out_valid timeout got 0 exp 1"); end
        else begin
            for (int k = 0; k < 5; k++) begin
                ncmp++; if (ov8 !== 1'b1) begin nfail++; $display("FAIL bp[%0d] out_valid got %b exp 1", k, ov8); end
                ncmp++; if (ir8 !== 1'b0) begin nfail++; $display("FAIL bp[%0d] in_ready got %b exp 0", k, ir8); end
                ncmp++; if (r8 !== 8'h25) begin nfail++; $display("FAIL bp[%0d] result got %h exp 25", k, r8); end
                ncmp++; if ({c8, o8, e8, z8} !== 4'b1000) begin nfail++; $display("FAIL bp[%0d] flags got %b exp 1000", k, {c8, o8, e8, z8}); end
                iv8 = ~iv8;
                a_t = rnd_operand(8, 1'b0); b_t = rnd_operand(8, 1'b0); sel_t = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            iv8 = 1'b0; or8 = 1'b1;
            @(posedge clk);
            #1 or8 = 1'b0;
            @(negedge clk);
            ncmp++; if (ir8 !== 1'b1) begin nfail++; $display("FAIL bp_release in_ready got %b exp 1", ir8); end
            ncmp++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL bp_release out_valid got %b exp 0", ov8); end
        end
    endtask

    task automatic test_reset_mid_bcd();
        logic [15:0] r; logic [3:0] f; int lat; logic rdy; bit to;
        sel_w = 8;
        @(negedge clk);
        for (int k = 0; k < 20 && !ir8; k++) @(negedge clk);
        a_t = 16'h0099; b_t = 16'h0099; sel_t = 2'b10; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        @(posedge clk);      // first digit done
        #1 rst = 1'b1;       // held across the second digit's edge
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        ncmp++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL midrst out_valid got %b exp 0", ov8); end
        ncmp++; if (r8 !== 8'h00) begin nfail++; $display("FAIL midrst result got %h exp 00", r8); end
        ncmp++; if ({c8, o8, e8, z8} !== 4'b0000) begin nfail++; $display("FAIL midrst flags got %b exp 0000", {c8, o8, e8, z8}); end
        ncmp++; if (ir8 !== 1'b1) begin nfail++; $display("FAIL midrst in_ready got %b exp 1", ir8); end
        run_op(8, 16'h0058, 16'h0067, 2'b10, r, f, lat, rdy, to);
        ncmp++;
        if (to !== 1'b0) begin nfail++; $display("FAIL midrst_op timeout got %0b exp 0", to); end
        else begin
            ncmp++; if (r !== 16'h0025) begin nfail++; $display("FAIL midrst_op result got %h exp 0025", r); end
            ncmp++; if (f !== 4'b1000) begin nfail++; $display("FAIL midrst_op flags got %b exp 1000", f); end
            ncmp++; if (lat != 3) begin nfail++; $display("FAIL midrst_op latency got %0d exp 3", lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa[$], qb[$];
        logic [1:0]  qs[$];
        logic [15:0] a, b, er; logic [3:0] ef; logic [1:0] s;
        int n_issued, n_done, last_acc, last_lat, cyc;
        logic prev_ov;
        n_issued = 0; n_done = 0; last_acc = -1; last_lat = 0; cyc = 0; prev_ov = 1'b0;
        sel_w = 8;
        or8 = 1'b1;
        @(negedge clk);
        while (n_done < 8 && cyc < 200) begin
            if (ov8) begin
                if (qa.size() == 0) begin
                    ncmp++; nfail++; $display("FAIL b2b unexpected_result got 1 exp 0");
                end else begin
                    a = qa.pop_front(); b = qb.pop_front(); s = qs.pop_front();
                    model(8, a, b, s, er, ef);
                    ncmp++; if ({8'h00, r8} !== er) begin nfail++; $display("FAIL b2b[%0d] result got %h exp %h", n_done, r8, er[7:0]); end
                    ncmp++; if ({c8, o8, e8, z8} !== ef) begin nfail++; $display("FAIL b2b[%0d] flags got %b exp %b", n_done, {c8, o8, e8, z8}, ef); end
                    ncmp++; if (prev_ov !== 1'b0) begin nfail++; $display("FAIL b2b[%0d] done_len got >1 exp 1 cycle", n_done); end
                end
                n_done++;
            end
            prev_ov = ov8;
            if (ir8 && n_issued < 8) begin
                s = 2'($urandom_range(0, 3));
                a = rnd_operand(8, 1'b1); b = rnd_operand(8, 1'b1);
                qa.push_back(a); qb.push_back(b); qs.push_back(s);
                a_t = a; b_t = b; sel_t = s; iv8 = 1'b1;
                if (last_acc >= 0) begin
                    ncmp++; if (cyc - last_acc != last_lat + 1) begin
                        nfail++; $display("FAIL b2b issue_interval got %0d exp %0d", cyc - last_acc, last_lat + 1); end
                end
                last_acc = cyc;
                last_lat = s[1] ? 3 : 2;
                n_issued++;
            end else begin
                iv8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        ncmp++; if (n_done != 8) begin nfail++; $display("FAIL b2b completed got %0d exp 8", n_done); end
    endtask

    initial begin
        tab[0]  = {5'd8,  16'h007F, 16'h0001, 2'b00, 16'h0080, 4'b0100};
        tab[1]  = {5'd8,  16'h0005, 16'h0007, 2'b01, 16'h00FE, 4'b0000};
        tab[2]  = {5'd8,  16'h0080, 16'h0001, 2'b01, 16'h007F, 4'b1100};
        tab[3]  = {5'd8,  16'h0033, 16'h0033, 2'b01, 16'h0000, 4'b1001};
        tab[4]  = {5'd8,  16'h00FF, 16'h0001, 2'b00, 16'h0000, 4'b1001};
        tab[5]  = {5'd8,  16'h0058, 16'h0067, 2'b10, 16'h0025, 4'b1000};
        tab[6]  = {5'd8,  16'h000A, 16'h0001, 2'b10, 16'h0011, 4'b0010};
        tab[7]  = {5'd8,  16'h0099, 16'h0001, 2'b10, 16'h0000, 4'b1001};
        tab[8]  = {5'd8,  16'h0042, 16'h0017, 2'b11, 16'h0025, 4'b1000};
        tab[9]  = {5'd8,  16'h0003, 16'h0005, 2'b11, 16'h0098, 4'b0000};
        tab[10] = {5'd16, 16'h1000, 16'h0001, 2'b11, 16'h0999, 4'b1000};

        test_reset();
        test_bin();
        test_bcd();
        test_random();
        test_backpressure();
        test_reset_mid_bcd();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
